// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its skid buffer.
package fetch_stage_pkg;

  localparam logic [31:0] FetchResetPc = 32'h0040_0000;
  localparam logic [31:0] FetchNop     = 32'h0000_0000;

  typedef enum logic [1:0] {
    FsIdle    = 2'd0,
    FsWait    = 2'd1,
    FsDiscard = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus_four;
  } fetch_entry_t;

  function automatic logic [31:0] pc_add4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_fetch_buffer.sv
// One-entry skid buffer holding a fetched word that decode could not accept.
module fetch_stage_fetch_buffer
  import fetch_stage_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         drain_i,
  input  logic         clear_i,
  input  fetch_entry_t data_i,
  output logic         valid_o,
  output fetch_entry_t data_o
);

  logic         valid_q;
  fetch_entry_t data_q;

  // Clear wins over load: a redirect squashes whatever arrives in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register: owns the PC, single-outstanding imem requests, decode redirects.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FetchResetPc
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall_D,
  input  logic        flush_D,
  input  logic        pc_src,
  input  logic [31:0] jump_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus_four,
  output logic        valid_D,
  output logic [31:0] pc_F
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  fetch_entry_t ifid_q, ifid_d;
  logic         ifid_valid_q, ifid_valid_d;

  logic         fb_valid;
  fetch_entry_t fb_data;
  fetch_entry_t resp;
  logic         redirect, issue, deliver, direct;

  assign redirect = pc_src & ifid_valid_q & ~stall_D;
  assign resp     = '{instr: imem_rdata, pc_plus_four: pc_add4(req_pc_q)};
  assign deliver  = (state_q == FsWait) & imem_valid & ~redirect;
  // A response goes straight into IF/ID only when decode can take it and nothing older waits.
  assign direct   = deliver & ~stall_D & ~fb_valid;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      FsIdle: begin
        if (!fb_valid && !redirect) begin
          issue   = 1'b1;
          state_d = FsWait;
        end
      end
      FsWait: begin
        if (redirect) begin
          state_d = imem_valid ? FsIdle : FsDiscard;
        end else if (imem_valid) begin
          if (direct) issue = 1'b1;
          else        state_d = FsIdle;
        end
      end
      FsDiscard: begin
        if (imem_valid) state_d = FsIdle;
      end
      default: state_d = FsIdle;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (redirect) begin
      pc_d = jump_address & ~32'h3;
    end else if (issue) begin
      pc_d     = pc_add4(pc_q);
      req_pc_d = pc_q;
    end
  end

  always_comb begin
    ifid_d       = '{instr: FetchNop, pc_plus_four: 32'h0};
    ifid_valid_d = 1'b0;
    if (flush_D || redirect) begin
      ifid_valid_d = 1'b0;
    end else if (stall_D) begin
      ifid_d       = ifid_q;
      ifid_valid_d = ifid_valid_q;
    end else if (fb_valid) begin
      ifid_d       = fb_data;
      ifid_valid_d = 1'b1;
    end else if (direct) begin
      ifid_d       = resp;
      ifid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= FsIdle;
      pc_q         <= RESET_PC;
      req_pc_q     <= 32'h0;
      ifid_q       <= '{instr: FetchNop, pc_plus_four: 32'h0};
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      ifid_q       <= ifid_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  fetch_stage_fetch_buffer u_fetch_buffer (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .load_i  (deliver & ~direct),
    .drain_i (fb_valid & ~flush_D & ~redirect & ~stall_D),
    .clear_i (redirect),
    .data_i  (resp),
    .valid_o (fb_valid),
    .data_o  (fb_data)
  );

  assign imem_req     = reset_n & issue;
  assign imem_addr    = pc_q;
  assign instruction  = ifid_q.instr;
  assign pc_plus_four = ifid_q.pc_plus_four;
  assign valid_D      = ifid_valid_q;
  assign pc_F         = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural fixed-latency instruction memory.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_D = 1'b0, flush_D = 1'b0, pc_src = 1'b0;
  logic [31:0] jump_address = 32'h0;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;

  logic        imem_req, valid_D;
  logic [31:0] imem_addr, instruction, pc_plus_four, pc_F;
  logic        imem_req2, valid_D2;
  logic [31:0] imem_addr2, instruction2, pc_plus_four2, pc_F2;

  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  bit          pend = 1'b0;
  int          pend_wait = 0;
  logic [31:0] pend_addr = 32'h0;
  logic        last_req;
  logic [31:0] last_addr, last_addr2;
  logic [31:0] exp_w;

  fetch_stage u_dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .stall_D      (stall_D),
    .flush_D      (flush_D),
    .pc_src       (pc_src),
    .jump_address (jump_address),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .pc_plus_four (pc_plus_four),
    .valid_D      (valid_D),
    .pc_F         (pc_F)
  );

  // Runs in lockstep with u_dut; only its addresses differ.
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clock        (clock),
    .reset_n      (reset_n),
    .stall_D      (stall_D),
    .flush_D      (flush_D),
    .pc_src       (pc_src),
    .jump_address (jump_address),
    .imem_req     (imem_req2),
    .imem_addr    (imem_addr2),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction2),
    .pc_plus_four (pc_plus_four2),
    .valid_D      (valid_D2),
    .pc_F         (pc_F2)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h2008_0001 + ((a - 32'h0040_0000) >> 2);
  endfunction

  // One clock: memory responds at negedge, requests captured just after, outputs sampled #1 past posedge.
  task automatic tick();
    @(negedge clock);
    if (pend && pend_wait == 0) begin
      imem_valid = 1'b1;
      imem_rdata = word(pend_addr);
      pend       = 1'b0;
    end else begin
      imem_valid = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      if (pend) pend_wait--;
    end
    #1;
    last_req   = imem_req;
    last_addr  = imem_addr;
    last_addr2 = imem_addr2;
    if (imem_req) begin
      checks++;
      if (pend) begin
        errors++;
        $display("FAIL single_outstanding: req to %h while %h pending", imem_addr, pend_addr);
      end
      pend      = 1'b1;
      pend_wait = lat - 1;
      pend_addr = imem_addr;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; stall_D = 1'b0; flush_D = 1'b0; pc_src = 1'b0;
    pend = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    checks++; if (valid_D !== 1'b0) begin errors++;
      $display("FAIL rst_valid: got %h exp 0", valid_D); end
    checks++; if (instruction !== 32'h0) begin errors++;
      $display("FAIL rst_instr: got %h exp 0", instruction); end
    checks++; if (pc_plus_four !== 32'h0) begin errors++;
      $display("FAIL rst_ppf: got %h exp 0", pc_plus_four); end
    checks++; if (pc_F !== 32'h0040_0000) begin errors++;
      $display("FAIL rst_pc: got %h exp 00400000", pc_F); end
    checks++; if (last_req !== 1'b0) begin errors++;
      $display("FAIL rst_req: got %h exp 0", last_req); end
    checks++; if (pc_F2 !== 32'hFFFF_FFFC) begin errors++;
      $display("FAIL rst_pc_param: got %h exp fffffffc", pc_F2); end
    reset_n = 1'b1;
  endtask

  task automatic test_stream();
    lat = 1;
    tick();
    checks++; if (last_req !== 1'b1 || last_addr !== 32'h0040_0000) begin errors++;
      $display("FAIL t1_first_req: got %h/%h exp 1/00400000", last_req, last_addr); end
    checks++; if (valid_D !== 1'b0) begin errors++;
      $display("FAIL t1_not_yet: got %h exp 0", valid_D); end
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_w = 32'h2008_0001 + i;
      checks++; if (valid_D !== 1'b1 || instruction !== exp_w) begin errors++;
        $display("FAIL t1_instr%0d: got %h/%h exp 1/%h", i, valid_D, instruction, exp_w); end
      exp_w = 32'h0040_0004 + 4 * i;
      checks++; if (pc_plus_four !== exp_w) begin errors++;
        $display("FAIL t1_ppf%0d: got %h exp %h", i, pc_plus_four, exp_w); end
    end
  endtask

  task automatic test_stall();
    stall_D = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (instruction !== 32'h2008_0004 || last_req !== 1'b0) begin errors++;
        $display("FAIL t2_hold%0d: got %h req %h exp 20080004 req 0", i, instruction, last_req);
      end
    end
    stall_D = 1'b0;
    tick();
    checks++; if (instruction !== 32'h2008_0005 || pc_plus_four !== 32'h0040_0014) begin
      errors++;
      $display("FAIL t2_fb_out: got %h/%h exp 20080005/00400014", instruction, pc_plus_four); end
    checks++; if (last_req !== 1'b0) begin errors++;
      $display("FAIL t2_no_req_fb: got %h exp 0", last_req); end
    tick();
    checks++; if (last_req !== 1'b1 || last_addr !== 32'h0040_0014 || valid_D !== 1'b0) begin
      errors++;
      $display("FAIL t2_resume: got %h/%h/%h exp 1/00400014/0", last_req, last_addr, valid_D);
    end
    tick();
    checks++; if (valid_D !== 1'b1 || instruction !== 32'h2008_0006) begin errors++;
      $display("FAIL t2_next: got %h/%h exp 1/20080006", valid_D, instruction); end
  endtask

  task automatic test_redirect();
    lat = 2;
    do_reset();
    repeat (7) tick();
    checks++; if (instruction !== 32'h2008_0003 || last_addr !== 32'h0040_000C) begin errors++;
      $display("FAIL t3_pre: got %h/%h exp 20080003/0040000c", instruction, last_addr); end
    pc_src = 1'b1; jump_address = 32'h0040_0100;
    tick();
    pc_src = 1'b0;
    checks++; if (valid_D !== 1'b0 || instruction !== 32'h0) begin errors++;
      $display("FAIL t3_squash: got %h/%h exp 0/0", valid_D, instruction); end
    checks++; if (pc_F !== 32'h0040_0100 || last_req !== 1'b0) begin errors++;
      $display("FAIL t3_pc: got %h req %h exp 00400100 req 0", pc_F, last_req); end
    tick();
    checks++; if (valid_D !== 1'b0 || last_req !== 1'b0) begin errors++;
      $display("FAIL t3_discard: got %h req %h exp 0 req 0", valid_D, last_req); end
    tick();
    checks++; if (last_req !== 1'b1 || last_addr !== 32'h0040_0100) begin errors++;
      $display("FAIL t3_target: got %h/%h exp 1/00400100", last_req, last_addr); end
    tick(); tick();
    checks++; if (instruction !== 32'h2008_0041 || pc_plus_four !== 32'h0040_0104) begin
      errors++;
      $display("FAIL t3_land: got %h/%h exp 20080041/00400104", instruction, pc_plus_four); end
  endtask

  task automatic test_flush();
    stall_D = 1'b1; flush_D = 1'b1;
    tick();
    stall_D = 1'b0; flush_D = 1'b0;
    checks++; if (valid_D !== 1'b0 || instruction !== 32'h0 || pc_plus_four !== 32'h0) begin
      errors++;
      $display("FAIL t4_flush: got %h/%h/%h exp 0/0/0", valid_D, instruction, pc_plus_four);
    end
    tick();
    checks++; if (valid_D !== 1'b1 || instruction !== 32'h2008_0042 ||
                  pc_plus_four !== 32'h0040_0108) begin errors++;
      $display("FAIL t4_after: got %h/%h/%h exp 1/20080042/00400108",
               valid_D, instruction, pc_plus_four); end
  endtask

  task automatic test_wrap_align();
    lat = 1;
    do_reset();
    tick();
    checks++; if (last_addr2 !== 32'hFFFF_FFFC || pc_F2 !== 32'h0) begin errors++;
      $display("FAIL t5_wrap_first: got %h pc %h exp fffffffc pc 0", last_addr2, pc_F2); end
    tick();
    checks++; if (last_addr2 !== 32'h0) begin errors++;
      $display("FAIL t5_wrap_second: got %h exp 00000000", last_addr2); end
    checks++; if (valid_D2 !== 1'b1 || pc_plus_four2 !== 32'h0) begin errors++;
      $display("FAIL t5_wrap_ppf: got %h/%h exp 1/0", valid_D2, pc_plus_four2); end
    pc_src = 1'b1; jump_address = 32'h0040_0102;
    tick();
    pc_src = 1'b0;
    checks++; if (pc_F !== 32'h0040_0100 || valid_D !== 1'b0) begin errors++;
      $display("FAIL t5_align_pc: got %h/%h exp 00400100/0", pc_F, valid_D); end
    tick();
    checks++; if (last_req !== 1'b1 || last_addr !== 32'h0040_0100) begin errors++;
      $display("FAIL t5_align_req: got %h/%h exp 1/00400100", last_req, last_addr); end
  endtask

  task automatic test_reset_midflight();
    // Skid buffer full at reset.
    lat = 1;
    do_reset();
    tick(); tick();
    stall_D = 1'b1;
    tick();
    checks++; if (instruction !== 32'h2008_0001 || last_req !== 1'b0) begin errors++;
      $display("FAIL t6_fb_fill: got %h req %h exp 20080001 req 0", instruction, last_req); end
    reset_n = 1'b0; stall_D = 1'b0;
    tick();
    checks++; if (valid_D !== 1'b0 || instruction !== 32'h0 || pc_plus_four !== 32'h0 ||
                  pc_F !== 32'h0040_0000) begin errors++;
      $display("FAIL t6_fb_reset: got %h/%h/%h/%h exp 0/0/0/00400000",
               valid_D, instruction, pc_plus_four, pc_F); end
    reset_n = 1'b1;
    tick();
    checks++; if (last_req !== 1'b1 || last_addr !== 32'h0040_0000) begin errors++;
      $display("FAIL t6_fb_restart: got %h/%h exp 1/00400000", last_req, last_addr); end
    tick();
    checks++; if (valid_D !== 1'b1 || instruction !== 32'h2008_0001) begin errors++;
      $display("FAIL t6_fb_first: got %h/%h exp 1/20080001", valid_D, instruction); end
    // Request outstanding at reset; its response lands in the first post-reset cycle.
    lat = 2;
    do_reset();
    tick(); tick(); tick();
    reset_n = 1'b0;
    tick();
    checks++; if (valid_D !== 1'b0 || instruction !== 32'h0 || pc_F !== 32'h0040_0000 ||
                  pc_F2 !== 32'hFFFF_FFFC) begin errors++;
      $display("FAIL t6_os_reset: got %h/%h/%h/%h exp 0/0/00400000/fffffffc",
               valid_D, instruction, pc_F, pc_F2); end
    reset_n = 1'b1;
    tick();
    checks++; if (last_req !== 1'b1 || last_addr !== 32'h0040_0000 || valid_D !== 1'b0) begin
      errors++;
      $display("FAIL t6_stale: got %h/%h/%h exp 1/00400000/0", last_req, last_addr, valid_D);
    end
    tick(); tick();
    checks++; if (instruction !== 32'h2008_0001 || pc_plus_four !== 32'h0040_0004) begin
      errors++;
      $display("FAIL t6_os_first: got %h/%h exp 20080001/00400004", instruction, pc_plus_four);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_flush();
    test_wrap_align();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
